// File: rtl/obi_sram_port_arbiter.sv
// Round-robin arbiter that shares one OBI SRAM port among NUM_REQ requesters.
// Grant IDs are kept in an in-order FIFO so each response goes back to the requester that issued it.
module obi_sram_port_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                m_req_i,
   output logic [NUM_REQ-1:0]                m_gnt_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     m_addr_i,
   input  logic [NUM_REQ-1:0]                m_we_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   m_be_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     m_wdata_i,
   output logic [NUM_REQ-1:0]                m_rvalid_o,
   output logic [DATA_WIDTH-1:0]             m_rdata_o,
   output logic                              s_req_o,
   input  logic                              s_gnt_i,
   output logic [ADDR_WIDTH-1:0]             s_addr_o,
   output logic                              s_we_o,
   output logic [DATA_WIDTH/8-1:0]           s_be_o,
   output logic [DATA_WIDTH-1:0]             s_wdata_o,
   input  logic                              s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]             s_rdata_i,
   output logic                              err_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             acc;
   logic             pop;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input logic [31:0]      off);
      return IDX_W'((32'(base) + off) % NUM_REQ);
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Scan from the farthest slot back to rr_ptr so the closest requester overwrites last.
   // NOTE: winner gets a default first so the combinational block never infers a latch.
   always_comb begin
      winner = rr_ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (m_req_i[rr_idx(rr_ptr, 32'(i))]) winner = rr_idx(rr_ptr, 32'(i));
      end
   end

   assign s_req_o   = (|m_req_i) && (count != CNT_MAX);
   assign acc       = s_req_o && s_gnt_i;
   assign pop       = s_rvalid_i && (count != '0);

   assign s_addr_o  = m_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
   assign s_we_o    = m_we_i[winner];
   assign s_be_o    = m_be_i[winner*BE_WIDTH +: BE_WIDTH];
   assign s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];

   assign m_gnt_o    = acc ? (NUM_REQ'(1) << winner) : '0;
   assign m_rvalid_o = pop ? (NUM_REQ'(1) << fifo_mem[head]) : '0;
   assign m_rdata_o  = s_rdata_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         err_o  <= 1'b0;
      end else begin
         if (acc) begin
            rr_ptr <= rr_idx(winner, 32'd1);
            tail   <= next_ptr(tail);
         end
         if (pop) head <= next_ptr(head);
         case ({acc, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
         // A response with nothing outstanding is a slave protocol violation; keep it visible.
         if (s_rvalid_i && (count == '0)) err_o <= 1'b1;
      end
   end

   // NOTE: FIFO storage is not reset; only entries between head and tail are ever read.
   always_ff @(posedge clk_i) begin
      if (acc) fifo_mem[tail] <= winner;
   end

endmodule

// File: doc/obi_sram_port_arbiter.md
Name: obi_sram_port_arbiter

Overview:
- Shares one OBI port of the double-port SRAM wrapper among NUM_REQ OBI requesters, e.g. core LSU lanes or a DMA.
- Arbitration is round-robin, so no requester starves.
- Tracks outstanding transactions in an in-order ID FIFO and routes each slave response back to the requester that issued it.
- Sits between the requesters and one SRAM port (req_0/rsp_0 or req_1/rsp_1).

Parameters:
- NUM_REQ, 4: number of requesters, at least 2.
- ADDR_WIDTH, 32: address width in bits.
- DATA_WIDTH, 32: data width in bits; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2: depth of the ID FIFO, i.e. the maximum number of accepted transactions awaiting rvalid.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- m_req_i  in  NUM_REQ  per-requester request
- m_gnt_o  out  NUM_REQ  per-requester grant, one-hot or zero
- m_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at slice k
- m_we_i  in  NUM_REQ  write enable
- m_be_i  in  NUM_REQ*DATA_WIDTH/8  byte enables
- m_wdata_i  in  NUM_REQ*DATA_WIDTH  write data
- m_rvalid_o  out  NUM_REQ  per-requester response valid, one-hot or zero
- m_rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters, qualified by m_rvalid_o
- s_req_o  out  1  request to the SRAM port
- s_gnt_i  in  1  SRAM grant
- s_addr_o  out  ADDR_WIDTH  address to the SRAM port
- s_we_o  out  1  write enable to the SRAM port
- s_be_o  out  DATA_WIDTH/8  byte enables to the SRAM port
- s_wdata_o  out  DATA_WIDTH  write data to the SRAM port
- s_rvalid_i  in  1  SRAM response valid
- s_rdata_i  in  DATA_WIDTH  SRAM read data
- err_o  out  1  sticky protocol error

Behaviour:
- Slave contract: the slave returns exactly one s_rvalid_i per accepted request (reads and writes), in order, at least 1 cycle after grant.
- Arbitration is combinational within a cycle.
  - winner = first k with m_req_i[k]=1, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
- Slave request and payload:
  - s_req_o = (|m_req_i) && (count < MAX_OUTSTANDING).
  - s_addr_o, s_we_o, s_be_o and s_wdata_o take the winner's slice.
  - When no request is active they take slice rr_ptr (don't-care).
- Accept:
  - acc = s_req_o && s_gnt_i.
  - m_gnt_o[winner] = acc; all other m_gnt_o bits are 0.
  - On acc: push winner into the ID FIFO and set rr_ptr <= (winner+1) mod NUM_REQ.
  - Without acc, rr_ptr holds.
- Response:
  - m_rvalid_o[fifo_head] = s_rvalid_i && (count != 0), combinational with zero added latency.
  - m_rdata_o = s_rdata_i.
  - On a valid response, pop the FIFO.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged; this is legal whenever count < MAX_OUTSTANDING gated the push.
- Full: when count == MAX_OUTSTANDING, s_req_o=0 and all m_gnt_o=0, even if s_rvalid_i pops in that cycle. There is no same-cycle refill.
- Empty: s_rvalid_i with count==0 is ignored. No m_rvalid_o is raised and err_o is set to 1 and stays at 1 until reset.
- Requester side: requesters hold m_req_i and the payload until granted. Deasserting before grant is tolerated: the request is simply not arbitrated.
- FIFO: a circular buffer with head/tail pointers of width clog2(MAX_OUTSTANDING), or 1 bit when MAX_OUTSTANDING=1; pointers wrap at MAX_OUTSTANDING.
- Reset (rst_i=1 at a clock edge):
  - rr_ptr=0, count=0, head=tail=0, err_o=0.
  - All combinational outputs follow from the reset state: s_req_o=0 unless a request is present on the next cycle.
  - Mid-operation reset discards in-flight IDs. Responses arriving afterwards hit the empty case and set err_o, so the slave must be reset together with this block.
- Registers: rr_ptr, FIFO storage, pointers, count and err_o only. No registered outputs; the gnt/rvalid paths are combinational.

Test Plan:
- Single requester: m_req_i=4'b0100, s_gnt_i=1, SRAM 1-cycle latency, read addr 0x40 -> m_gnt_o=4'b0100 in cycle 0; m_rvalid_o=4'b0100 with the SRAM word in cycle 1; rr_ptr=3.
- All four requesting continuously, s_gnt_i=1, responses 1 cycle later -> grant order 0,1,2,3,0,1 in consecutive cycles; each m_rvalid_o arrives one cycle after its own grant.
- Back-pressure with MAX_OUTSTANDING=2: slave withholds rvalid for 5 cycles while requester 1 keeps requesting -> 2 grants, then s_req_o=0 and no grants. The first rvalid pops one entry, and the next cycle grants again.
- Interleaved read/write from requesters 0 and 2: write 0xDEADBEEF be=4'hF to addr 0x10 by req 0, then read 0x10 by req 2 -> req 2 receives 0xDEADBEEF; req 0 gets exactly one rvalid for the write.
- Spurious s_rvalid_i pulse with count=0 -> all m_rvalid_o=0, err_o=1 and stays at 1 until rst_i. After rst_i, err_o=0.
- Reset mid-stream with 2 outstanding -> next cycle count=0, rr_ptr=0. With m_req_i=4'b1010, requester 1 wins first.
